// File: rtl/sd_rx_pkg.sv
// Shared definitions for the SD RX data deserializer: FSM states, CRC16
// constants, start/stop nibble values and the serial CRC step function.
package sd_rx_pkg;

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned CRC_LEN   = 16;
   localparam logic [CRC_LEN-1:0] CRC_POLY = 16'h1021;

   localparam logic [3:0] START_NIB = 4'h0;
   localparam logic [3:0] STOP_NIB  = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_START = 3'd1,
      ST_DATA       = 3'd2,
      ST_CRC        = 3'd3,
      ST_STOP       = 3'd4,
      ST_DONE       = 3'd5
   } state_t;

   // One serial step of CRC16 x^16+x^12+x^5+1, MSB-first feedback.
   function automatic logic [CRC_LEN-1:0] crc16_next(
      input logic [CRC_LEN-1:0] crc,
      input logic               din
   );
      logic fb;
      fb = crc[CRC_LEN-1] ^ din;
      return {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
   endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// One-lane serial CRC16 generator with synchronous clear and update enable.
module sd_crc16_serial
   import sd_rx_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic               din,
   output logic [CRC_LEN-1:0] crc
);

   // CRC register: cleared on reset/clear, advanced one bit per enabled cycle
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         crc <= '0;
      end else if (en) begin
         crc <= crc16_next(crc, din);
      end
   end

endmodule

// File: rtl/sd_rx_data_deser.sv
// SD DAT receive deserializer: start-bit detection with timeout, nibble
// forwarding to the RX FIFO write side, per-lane CRC16 and stop-bit checks.
// Optional 1-bit bus mode is compiled in when SD_RX_BUS1_EN is defined.
module sd_rx_data_deser
   import sd_rx_pkg::*;
#(
   parameter int unsigned BLK_W = 12,
   parameter int unsigned TO_W  = 16
) (
   input  logic             sd_clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             abort_i,
   input  logic [BLK_W-1:0] blksize_i,
   input  logic [TO_W-1:0]  timeout_i,
   input  logic [3:0]       dat_i,
   input  logic             fifo_full_i,
`ifdef SD_RX_BUS1_EN
   input  logic             bus_1bit_i,
`endif
   output logic [3:0]       fifo_d_o,
   output logic             fifo_wr_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             crc_err_o,
   output logic             timeout_o,
   output logic             ovf_o
);

   state_t             state;
   state_t             state_nxt;

   logic [BLK_W:0]     nib_cnt;
   logic [TO_W-1:0]    to_cnt;
   logic [3:0]         crc_idx;
   logic [3:0]         crc_sel;
   logic [3:0]         d_q;
   logic               wr_pend;
   logic               crc_err_q;
   logic               ovf_q;
   logic               timeout_q;

   logic [CRC_LEN-1:0] crc_q [NUM_LANES];
   logic               crc_clr;
   logic               crc_en;

   logic               accept;
   logic               mode_1bit;
   logic               nib_step;
   logic [3:0]         nib_val;
   logic               is_start;
   logic               is_stop;
   logic               last_nib;
   logic               to_expire;
   logic [3:0]         lane_chk;
   logic               crc_mis;

   assign accept    = (state == ST_IDLE) && en_i && !abort_i;
   assign is_start  = mode_1bit ? ~dat_i[0] : (dat_i == START_NIB);
   assign is_stop   = mode_1bit ?  dat_i[0] : (dat_i == STOP_NIB);
   assign last_nib  = nib_step && (nib_cnt == (BLK_W+1)'(1));
   // A loaded count of 0 never reaches 1, so a zero timeout never expires
   assign to_expire = (to_cnt == TO_W'(1));
   assign lane_chk  = mode_1bit ? 4'b0001 : 4'b1111;
   // Received CRC bits arrive MSB first: bit index 15-crc_idx
   assign crc_sel   = ~crc_idx;
   assign crc_clr   = accept;
   assign crc_en    = (state == ST_DATA) && !abort_i;

`ifdef SD_RX_BUS1_EN
   logic       bus1_q;
   logic [1:0] bit_cnt;
   logic [2:0] shreg;

   assign mode_1bit = bus1_q;
   assign nib_step  = ~bus1_q | (bit_cnt == 2'd3);
   assign nib_val   = bus1_q ? {shreg, dat_i[0]} : dat_i;

   // 1-bit mode: latch bus width at arm time and assemble nibbles MSB first
   always_ff @(posedge sd_clk) begin
      if (rst) begin
         bus1_q  <= 1'b0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (accept) begin
         bus1_q  <= bus_1bit_i;
         bit_cnt <= '0;
         shreg   <= '0;
      end else if ((state == ST_DATA) && !abort_i) begin
         shreg   <= {shreg[1:0], dat_i[0]};
         bit_cnt <= bit_cnt + 2'd1;
      end
   end
`else
   assign mode_1bit = 1'b0;
   assign nib_step  = 1'b1;
   assign nib_val   = dat_i;
`endif

   // Per-lane CRC16 engines fed directly from the DAT lines
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      sd_crc16_serial u_crc (
         .clk (sd_clk),
         .rst (rst),
         .clr (crc_clr),
         .en  (crc_en),
         .din (dat_i[g]),
         .crc (crc_q[g])
      );
   end

   // Compare received CRC bit against the computed CRC on every checked lane
   always_comb begin
      crc_mis = 1'b0;
      for (int unsigned n = 0; n < NUM_LANES; n++) begin
         if (lane_chk[n] && (dat_i[n] != crc_q[n][crc_sel])) begin
            crc_mis = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge sd_clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort has priority in every active state
   always_comb begin
      state_nxt = state;
      if ((state != ST_IDLE) && abort_i) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  state_nxt = ST_WAIT_START;
               end
            end
            ST_WAIT_START: begin
               if (is_start) begin
                  state_nxt = ST_DATA;
               end else if (to_expire) begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_DATA: begin
               if (last_nib) begin
                  state_nxt = ST_CRC;
               end
            end
            ST_CRC: begin
               if (crc_idx == 4'd15) begin
                  state_nxt = ST_STOP;
               end
            end
            ST_STOP: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State-decoded outputs
   always_comb begin
      busy_o = (state != ST_IDLE);
      done_o = (state == ST_DONE);
   end

   // Datapath: counters, nibble register, status flags
   always_ff @(posedge sd_clk) begin
      if (rst) begin
         nib_cnt   <= '0;
         to_cnt    <= '0;
         crc_idx   <= '0;
         d_q       <= '0;
         wr_pend   <= 1'b0;
         crc_err_q <= 1'b0;
         ovf_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         wr_pend   <= 1'b0;
         // A write blocked by a full FIFO is dropped but remembered
         if (wr_pend && fifo_full_i) begin
            ovf_q <= 1'b1;
         end
         if ((state != ST_IDLE) && abort_i) begin
            crc_err_q <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     nib_cnt   <= {blksize_i, 1'b0};
                     to_cnt    <= timeout_i;
                     crc_idx   <= '0;
                     crc_err_q <= 1'b0;
                     ovf_q     <= 1'b0;
                  end
               end
               ST_WAIT_START: begin
                  if (!is_start && (to_cnt != '0)) begin
                     to_cnt <= to_cnt - 1'b1;
                     if (to_expire) begin
                        timeout_q <= 1'b1;
                     end
                  end
               end
               ST_DATA: begin
                  if (nib_step) begin
                     d_q     <= nib_val;
                     wr_pend <= 1'b1;
                     nib_cnt <= nib_cnt - 1'b1;
                  end
               end
               ST_CRC: begin
                  if (crc_mis) begin
                     crc_err_q <= 1'b1;
                  end
                  crc_idx <= crc_idx + 4'd1;
               end
               ST_STOP: begin
                  if (!is_stop) begin
                     crc_err_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign fifo_d_o  = d_q;
   assign fifo_wr_o = wr_pend & ~fifo_full_i;
   assign crc_err_o = crc_err_q;
   assign ovf_o     = ovf_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_sd_rx_data_deser.sv
// Scoreboard bench for sd_rx_data_deser (BLK_W=3 so blksize 0 is cheap).
// 1-bit mode test is included when SD_RX_BUS1_EN is defined.
module tb_sd_rx_data_deser;

   logic        sd_clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        abort = 1'b0;
   logic [2:0]  blksize = '0;
   logic [15:0] timeout = '0;
   logic [3:0]  dat = 4'hF;
   logic        full = 1'b0;
`ifdef SD_RX_BUS1_EN
   logic        bus1 = 1'b0;
`endif
   logic [3:0]  fifo_d;
   logic        fifo_wr, busy, done, crc_err, to_p, ovf;

   int n_vec = 0;
   int n_bad = 0;

   logic [3:0] wq [$];
   logic [1:0] dq [$];
   logic       tq [$];
   logic [3:0] ew;
   logic [1:0] ed;
   logic       et;

   sd_rx_data_deser #(.BLK_W(3), .TO_W(16)) dut (
      .sd_clk      (sd_clk),
      .rst         (rst),
      .en_i        (en),
      .abort_i     (abort),
      .blksize_i   (blksize),
      .timeout_i   (timeout),
      .dat_i       (dat),
      .fifo_full_i (full),
`ifdef SD_RX_BUS1_EN
      .bus_1bit_i  (bus1),
`endif
      .fifo_d_o    (fifo_d),
      .fifo_wr_o   (fifo_wr),
      .busy_o      (busy),
      .done_o      (done),
      .crc_err_o   (crc_err),
      .timeout_o   (to_p),
      .ovf_o       (ovf)
   );

   always #5 sd_clk = ~sd_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      n_vec++;
      n_bad++;
      $display("FAIL %s: output seen with nothing expected", nm);
   endtask

   // Monitor: pops expectations whenever the DUT presents an event
   always @(negedge sd_clk) begin
      if (fifo_wr === 1'b1) begin
         if (wq.size() == 0) unexpected("fifo_wr");
         else begin
            ew = wq.pop_front();
            chk("wr_data", {12'h0, fifo_d}, {12'h0, ew});
         end
      end
      if (done === 1'b1) begin
         if (dq.size() == 0) unexpected("done");
         else begin
            ed = dq.pop_front();
            chk("done_crc_err", {15'h0, crc_err}, {15'h0, ed[1]});
            chk("done_ovf", {15'h0, ovf}, {15'h0, ed[0]});
         end
      end
      if (to_p === 1'b1) begin
         if (tq.size() == 0) unexpected("timeout");
         else et = tq.pop_front();
      end
   end

   task automatic step();
      @(posedge sd_clk);
      #1;
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic [15:0] r;
      r = {c[14:0], 1'b0};
      if (c[15] ^ b) r = r ^ 16'h1021;
      return r;
   endfunction

   task automatic run_block(input int blk, input logic [3:0] first, input int full_at,
                            input int flip_lane, input int flip_bit, input logic [3:0] stop_v,
                            input int abort_at, input int rst_at);
      int nn, cut;
      logic [3:0]  nib [16];
      logic [15:0] c [4];
      logic err;
      nn = (blk == 0) ? 16 : 2 * blk;
      for (int n = 0; n < 4; n++) c[n] = '0;
      for (int i = 0; i < nn; i++) begin
         nib[i] = first + 4'(i);
         for (int n = 0; n < 4; n++) c[n] = crc_step(c[n], nib[i][n]);
      end
      if (flip_lane >= 0) c[flip_lane][flip_bit] = ~c[flip_lane][flip_bit];
      cut = nn;
      if (abort_at >= 0) cut = abort_at;
      else if (rst_at >= 0) cut = rst_at;
      for (int i = 0; i < cut; i++) if (i != full_at) wq.push_back(nib[i]);
      err = (flip_lane >= 0) || (stop_v != 4'hF);
      if (cut == nn) dq.push_back({err, full_at >= 0});

      blksize = 3'(blk);
      timeout = '0;
      en = 1'b1;
      step();
      en = 1'b0;
      dat = 4'hF;
      step();
      step();
      dat = 4'h0;
      step();
      for (int i = 0; i < nn; i++) begin
         dat = nib[i];
         full = (full_at >= 0) && (i == full_at + 1);
         if (i == abort_at) abort = 1'b1;
         if (i == rst_at) rst = 1'b1;
         step();
         if (abort || rst) begin
            abort = 1'b0;
            rst = 1'b0;
            full = 1'b0;
            dat = 4'hF;
            chk("busy_after_cut", {15'h0, busy}, 16'h0);
            chk("wr_after_cut", {15'h0, fifo_wr}, 16'h0);
            chk("done_after_cut", {15'h0, done}, 16'h0);
            if (rst_at >= 0) begin
               chk("rst_fifo_d", {12'h0, fifo_d}, 16'h0);
               chk("rst_flags", {13'h0, crc_err, ovf, to_p}, 16'h0);
            end
            for (int k = 0; k < 4; k++) step();
            return;
         end
      end
      for (int k = 0; k < 16; k++) begin
         dat = {c[3][15-k], c[2][15-k], c[1][15-k], c[0][15-k]};
         full = (k == 0) && (full_at == nn - 1);
         step();
      end
      full = 1'b0;
      dat = stop_v;
      step();
      chk("done_after_stop", {15'h0, done}, 16'h1);
      dat = 4'hF;
      step();
      chk("done_one_cycle", {15'h0, done}, 16'h0);
      chk("busy_after_done", {15'h0, busy}, 16'h0);
      step();
   endtask

`ifdef SD_RX_BUS1_EN
   task automatic run_1bit();
      logic [7:0]  bits;
      logic [15:0] c;
      bits = 8'hA5;
      c = '0;
      for (int k = 0; k < 8; k++) c = crc_step(c, bits[7-k]);
      wq.push_back(4'hA);
      wq.push_back(4'h5);
      dq.push_back(2'b00);
      blksize = 3'd1;
      bus1 = 1'b1;
      en = 1'b1;
      step();
      en = 1'b0;
      bus1 = 1'b0;
      dat = 4'hF;
      step();
      dat = 4'b1110;
      step();
      for (int k = 0; k < 8; k++) begin
         dat = {3'b010, bits[7-k]};
         step();
      end
      for (int k = 0; k < 16; k++) begin
         dat = {3'b101, c[15-k]};
         step();
      end
      dat = 4'b0001;
      step();
      chk("bus1_done", {15'h0, done}, 16'h1);
      dat = 4'hF;
      step();
      step();
   endtask
`endif

   initial begin
      step();
      step();
      chk("reset_outputs", {fifo_d, 6'h0, fifo_wr, busy, done, crc_err, to_p, ovf}, 16'h0);
      rst = 1'b0;
      step();
      chk("idle_busy", {15'h0, busy}, 16'h0);

      // good block, nibbles 0..7
      run_block(4, 4'h0, -1, -1, 0, 4'hF, -1, -1);
      // CRC bit flipped on lane 2
      run_block(4, 4'h0, -1, 2, 5, 4'hF, -1, -1);

      // start-bit timeout with T=10
      tq.push_back(1'b1);
      timeout = 16'd10;
      dat = 4'hF;
      en = 1'b1;
      step();
      en = 1'b0;
      for (int k = 1; k < 10; k++) step();
      chk("timeout_early", {15'h0, to_p}, 16'h0);
      chk("busy_waiting", {15'h0, busy}, 16'h1);
      step();
      chk("timeout_pulse", {15'h0, to_p}, 16'h1);
      chk("busy_after_timeout", {15'h0, busy}, 16'h0);
      step();
      chk("timeout_one_cycle", {15'h0, to_p}, 16'h0);
      timeout = '0;

      // FIFO full while nibble 3 would be written
      run_block(4, 4'h0, 3, -1, 0, 4'hF, -1, -1);
      chk("ovf_sticky", {15'h0, ovf}, 16'h1);

      // abort at nibble 5, then a clean block
      run_block(4, 4'h0, -1, -1, 0, 4'hF, 5, -1);
      run_block(4, 4'h8, -1, -1, 0, 4'hF, -1, -1);

      // en and abort together in IDLE
      en = 1'b1;
      abort = 1'b1;
      step();
      en = 1'b0;
      abort = 1'b0;
      chk("en_abort_idle", {15'h0, busy}, 16'h0);
      step();

      // bad stop nibble
      run_block(4, 4'h3, -1, -1, 0, 4'hE, -1, -1);
      // blksize 0 -> 16 nibbles
      run_block(0, 4'h9, -1, -1, 0, 4'hF, -1, -1);
      // reset at nibble 2, then a clean block
      run_block(4, 4'h5, -1, -1, 0, 4'hF, -1, 2);
      run_block(4, 4'h2, -1, -1, 0, 4'hF, -1, -1);
`ifdef SD_RX_BUS1_EN
      run_1bit();
`endif
      step();
      step();
      chk("wr_queue_empty", 16'(wq.size()), 16'h0);
      chk("done_queue_empty", 16'(dq.size()), 16'h0);
      chk("timeout_queue_empty", 16'(tq.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
